// File: rtl/multu_hilo_seq_if.sv
// multu_hilo_seq_if: request/response bundle between the core and the HI/LO multiply unit
interface multu_hilo_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             rd_stall;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (
    output start, ctl, a, b,
    input  busy, done, rd_stall, result, hi, lo
  );
  modport slave (
    input  start, ctl, a, b,
    output busy, done, rd_stall, result, hi, lo
  );
endinterface

// File: rtl/multu_hilo_seq.sv
// multu_hilo_seq: WIDTH-cycle shift-add unsigned multiplier into HI/LO with MFHI/MFLO reads.
// Define MULTU_MTHILO_EN to add the MTHI/MTLO register writes.
module multu_hilo_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multu_hilo_seq_if.slave      bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
`ifdef MULTU_MTHILO_EN
  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;
`endif
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] hi, lo, mcand;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;
  logic             ready, accept;
  assign ready  = state != RUN;
  assign accept = ready && bus.start && bus.ctl == MULTU;
  // carry out of the add becomes the new HI MSB as {hi,lo} shifts right
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      count <= '0;
    end else if (accept) begin
      mcand <= bus.a;
      hi    <= '0;
      lo    <= bus.b;
      count <= '0;
      state <= RUN;
`ifdef MULTU_MTHILO_EN
    end else if (ready && bus.start && bus.ctl == MTHI) begin
      hi    <= bus.a;
      state <= IDLE;
    end else if (ready && bus.start && bus.ctl == MTLO) begin
      lo    <= bus.a;
      state <= IDLE;
`endif
    end else if (state == RUN) begin
      {hi, lo} <= {sum, lo[WIDTH-1:1]};
      count    <= count + 1'b1;
      state    <= (count == CW'(WIDTH - 1)) ? DONE : RUN;
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
  assign bus.busy     = state == RUN;
  assign bus.done     = state == DONE;
  assign bus.rd_stall = bus.busy && (bus.ctl == MFHI || bus.ctl == MFLO);
  assign bus.result   = (bus.ctl == MFHI) ? hi : (bus.ctl == MFLO) ? lo : '0;
  assign bus.hi       = hi;
  assign bus.lo       = lo;
endmodule

// File: tb/tb_multu_hilo_seq.sv
// tb_multu_hilo_seq: directed-vector bench for the HI/LO shift-add multiplier.
module tb_multu_hilo_seq;
  localparam int W = 32;
  localparam logic [5:0] MULTU = 6'd25;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  localparam logic [5:0] MTHI  = 6'b010001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  multu_hilo_seq_if #(.WIDTH(W)) bus ();
  multu_hilo_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic issue(input logic [5:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    bus.start = 1'b1;
    bus.ctl = c;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ctl = 6'd0;
  endtask
  task automatic wait_done(output int cyc, output logic seen);
    cyc = 0;
    while (bus.busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    seen = bus.done;
  endtask
  task automatic test_reset;
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all zero", bus.busy, bus.done, bus.hi, bus.lo);
    end
  endtask
  task automatic test_small;
    int cyc;
    logic seen;
    issue(MULTU, 32'd3, 32'd5);
    wait_done(cyc, seen);
    vectors++;
    if (cyc !== 32) begin
      miscompares++;
      $display("FAIL small_latency: busy cycles %0d, required 32", cyc);
    end
    vectors++;
    if (seen !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd15) begin
      miscompares++;
      $display("FAIL small_product: done=%b hi=%h lo=%h, required 1/0/f", seen, bus.hi, bus.lo);
    end
    @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b one cycle later, required 0", bus.done);
    end
  endtask
  task automatic test_carry;
    int cyc;
    logic seen;
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, seen);
    vectors++;
    if (seen !== 1'b1 || bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin
      miscompares++;
      $display("FAIL carry: done=%b hi=%h lo=%h, required 1/fffffffe/00000001", seen, bus.hi, bus.lo);
    end
  endtask
  task automatic test_reads;
    int cyc;
    logic seen;
    issue(MULTU, 32'h8000_0000, 32'd2);
    wait_done(cyc, seen);
    vectors++;
    if (bus.hi !== 32'd1 || bus.lo !== 32'd0) begin
      miscompares++;
      $display("FAIL msb_product: hi=%h lo=%h, required 1/0", bus.hi, bus.lo);
    end
    bus.ctl = MFHI;
    #1;
    vectors++;
    if (bus.result !== 32'd1 || bus.rd_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL mfhi: result=%h stall=%b, required 1/0", bus.result, bus.rd_stall);
    end
    bus.ctl = MFLO;
    #1;
    vectors++;
    if (bus.result !== 32'd0) begin
      miscompares++;
      $display("FAIL mflo: result=%h, required 0", bus.result);
    end
    bus.ctl = 6'd0;
  endtask
  task automatic test_busy_ignore;
    int cyc;
    logic seen;
    issue(MULTU, 32'd100, 32'd200);
    bus.start = 1'b1;
    bus.ctl = MULTU;
    bus.a = 32'd7;
    bus.b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ctl = MFLO;
    #1;
    vectors++;
    if (bus.rd_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_stall: stall=%b while busy, required 1", bus.rd_stall);
    end
    bus.ctl = 6'd0;
    wait_done(cyc, seen);
    vectors++;
    if (cyc !== 31 || seen !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd20000) begin
      miscompares++;
      $display("FAIL busy_ignore: cyc=%0d done=%b hi=%h lo=%h, required 31/1/0/4e20", cyc, seen, bus.hi, bus.lo);
    end
  endtask
  task automatic test_abort;
    int cyc;
    logic seen;
    logic saw_done = 1'b0;
    issue(MULTU, 32'd123456, 32'd789);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.hi !== '0 || bus.lo !== '0) begin
      miscompares++;
      $display("FAIL abort: busy=%b hi=%h lo=%h, required 0/0/0", bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      saw_done |= bus.done;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_done: done seen=%b, required 0", saw_done);
    end
    issue(MULTU, 32'd6, 32'd7);
    wait_done(cyc, seen);
    vectors++;
    if (seen !== 1'b1 || bus.hi !== 32'd0 || bus.lo !== 32'd42) begin
      miscompares++;
      $display("FAIL after_abort: done=%b hi=%h lo=%h, required 1/0/2a", seen, bus.hi, bus.lo);
    end
  endtask
  task automatic test_back_to_back;
    int cyc;
    logic seen;
    issue(MULTU, 32'd9, 32'd11);
    wait_done(cyc, seen);
    bus.start = 1'b1;
    bus.ctl = MULTU;
    bus.a = 32'h0001_0000;
    bus.b = 32'h0003_0000;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ctl = 6'd0;
    wait_done(cyc, seen);
    vectors++;
    if (cyc !== 32 || seen !== 1'b1 || bus.hi !== 32'd3 || bus.lo !== 32'd0) begin
      miscompares++;
      $display("FAIL back_to_back: cyc=%0d done=%b hi=%h lo=%h, required 32/1/3/0", cyc, seen, bus.hi, bus.lo);
    end
  endtask
  task automatic test_unknown_and_mthi;
    logic [W-1:0] hi0, lo0;
    hi0 = bus.hi;
    lo0 = bus.lo;
    issue(6'd3, 32'h1234_5678, 32'h9);
    vectors++;
    if (bus.busy !== 1'b0 || bus.hi !== hi0 || bus.lo !== lo0) begin
      miscompares++;
      $display("FAIL unknown_ctl: busy=%b hi=%h lo=%h, required 0/%h/%h", bus.busy, bus.hi, bus.lo, hi0, lo0);
    end
    issue(MTHI, 32'hDEAD_BEEF, 32'd0);
`ifdef MULTU_MTHILO_EN
    vectors++;
    if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== lo0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi: hi=%h lo=%h busy=%b, required deadbeef/%h/0", bus.hi, bus.lo, bus.busy, lo0);
    end
`else
    vectors++;
    if (bus.hi !== hi0 || bus.lo !== lo0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi_disabled: hi=%h lo=%h busy=%b, required %h/%h/0", bus.hi, bus.lo, bus.busy, hi0, lo0);
    end
`endif
  endtask
  initial begin
    bus.start = 1'b0;
    bus.ctl = 6'd0;
    bus.a = '0;
    bus.b = '0;
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    test_small;
    test_carry;
    test_reads;
    test_busy_ignore;
    test_abort;
    test_back_to_back;
    test_unknown_and_mthi;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
